id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the 64-bit ALU.
- Registers the decoded instruction from ID and derives the 4-bit ALU operation code from the main-control ALUOp and funct fields.
- Forwards operands from the EX/MEM and MEM/WB stages, then drives the ALU a/b inputs.
- Detects load-use hazards and inserts bubbles; supports pipeline stall and flush through valid/ready handshakes.

Parameters:
XLEN, 64, datapath width (ALU operand width)
RA_W, 5, register-address width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  ID presents an instruction
in_ready  output  1  stage accepts the ID instruction this cycle
in_rs1_data  input  XLEN  register file read port 1
in_rs2_data  input  XLEN  register file read port 2
in_imm  input  XLEN  sign-extended immediate
in_rs1, in_rs2, in_rd  input  RA_W each  source/destination addresses
in_aluop  input  2  main-control ALUOp (00 mem, 01 branch, 10 R/I-arith)
in_funct3  input  3  instruction funct3
in_f7b30  input  1  instruction bit 30
in_rtype  input  1  1 = R-type (bit 30 selects sub)
in_alusrc  input  1  1 = b operand is immediate
in_ctrl  input  5  {branch, memread, memwrite, memtoreg, regwrite}
exm_regwrite  input  1  EX/MEM writes a register
exm_rd  input  RA_W  EX/MEM destination
exm_result  input  XLEN  EX/MEM ALU result
mwb_regwrite  input  1  MEM/WB writes a register
mwb_rd  input  RA_W  MEM/WB destination
mwb_result  input  XLEN  MEM/WB write-back data
flush  input  1  kill EX-held and incoming instruction
out_valid  output  1  EX holds a valid instruction
out_ready  input  1  downstream (EX/MEM) accepts
alu_a  output  XLEN  to ALU a
alu_b  output  XLEN  to ALU b
alu_op  output  4  to ALU ALUop
store_data  output  XLEN  forwarded rs2 value for stores
out_rd  output  RA_W  registered rd
out_ctrl  output  5  registered in_ctrl

Behaviour:
- State: one register bank {valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alusrc, ctrl, alu_op}.
- Reset: all state, including valid, is 0. Resulting outputs: out_valid=0, alu_op=0000, out_rd=0, out_ctrl=0. alu_a, alu_b and store_data are 0 when no forward matches. Reset overrides flush and stall.
- ALU-op decode, computed at capture and registered:
  - ALUOp 00 → 0010 (add).
  - ALUOp 01 → 0110 (sub).
  - ALUOp 10, funct3 000: 0110 if rtype&f7b30, else 0010.
  - ALUOp 10, funct3 111 → 0000; funct3 110 → 0001; funct3 001 → 1000.
  - Any other funct3 → 0010. ALUOp 11 → 0010.
- Load-use hazard (combinational): valid & ctrl.memread & rd≠0 & in_valid & (in_rs1==rd | in_rs2==rd).
- in_ready = flush | (out_ready & ~hazard).
- Next-state priority:
  1. reset.
  2. flush: valid←0, incoming discarded.
  3. ~out_ready: hold all state.
  4. hazard: valid←0 (bubble). ID is held because in_ready=0.
  5. Otherwise: capture the ID fields; valid←in_valid.
- Captured fields are don't-care when the captured valid=0, except ctrl, which is forced to 0 so that a bubble never writes.
- Forwarding (combinational, on registered rs1/rs2):
  - A source equal to 0 is never forwarded.
  - EX/MEM match (exm_regwrite & exm_rd==rs) has priority over a MEM/WB match; otherwise the registered read data is used.
  - alu_a = fwd_rs1; store_data = fwd_rs2; alu_b = alusrc ? imm : fwd_rs2.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1. Throughput is one per cycle absent hazard or stall.
- Simultaneous flush and hazard: flush wins and in_ready=1.
- Outputs remain stable for the whole time ~out_ready is asserted.

Test Plan:
- Reset with in_valid=1 → out_valid=0, alu_op=0000, out_ctrl=0. Release reset, inject add x3,x1,x2 with rs1_data=5, rs2_data=7 → next cycle alu_a=5, alu_b=7, alu_op=0010.
- R-type sub (rtype=1, f7b30=1, funct3=000) → alu_op=0110. Also check funct3 111/110/001 → 0000/0001/1000, and ALUOp 01 → 0110.
- Forwarding: EX rs1=3 with exm_rd=3, exm_result=0x10, mwb_rd=3, mwb_result=0x20 → alu_a=0x10. Drop exm_regwrite → alu_a=0x20. Set rs1=0 → no forward.
- Load-use: ld x4 in EX, then in_valid with in_rs2=4 → in_ready=0 for one cycle and a bubble (out_valid=0, out_ctrl=0). Next cycle in_ready=1 and the instruction is captured.
- Stall: out_ready=0 for 3 cycles → in_ready=0 and outputs unchanged. On release, the next instruction advances.
- Flush while a hazard is present → in_ready=1 and next cycle out_valid=0. Reset asserted mid-stream → out_valid=0 the next cycle.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: decodes the ALU operation at capture,
// forwards EX/MEM and MEM/WB results onto the operands, and inserts load-use bubbles.
module id_ex_operand_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_f7b30,
    input  logic            in_rtype,
    input  logic            in_alusrc,
    input  logic [4:0]      in_ctrl,
    input  logic            exm_regwrite,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_regwrite,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic [RA_W-1:0] out_rd,
    output logic [4:0]      out_ctrl
);

    localparam int CTRL_MEMREAD = 3;

    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic            r_alusrc;
    logic [4:0]      r_ctrl;
    logic [3:0]      r_alu_op;

    logic            w_hazard;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // NOTE: every branch of a combinational block must assign its outputs; the default first keeps it latch-free.
    always_comb begin
        w_alu_op = 4'b0010;
        unique case (in_aluop)
            2'b01: w_alu_op = 4'b0110;
            2'b10: begin
                unique case (in_funct3)
                    3'b000:  w_alu_op = (in_rtype && in_f7b30) ? 4'b0110 : 4'b0010;
                    3'b111:  w_alu_op = 4'b0000;
                    3'b110:  w_alu_op = 4'b0001;
                    3'b001:  w_alu_op = 4'b1000;
                    default: w_alu_op = 4'b0010;
                endcase
            end
            default: w_alu_op = 4'b0010;
        endcase
    end

    // A load in EX cannot supply its data to the very next instruction; stall it one cycle.
    assign w_hazard = r_valid && r_ctrl[CTRL_MEMREAD] && (r_rd != '0) && in_valid &&
                      ((in_rs1 == r_rd) || (in_rs2 == r_rd));

    assign in_ready = flush || (out_ready && !w_hazard);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alusrc   <= 1'b0;
            r_ctrl     <= '0;
            r_alu_op   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!out_ready) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid    <= in_valid;
            r_rs1_data <= in_rs1_data;
            r_rs2_data <= in_rs2_data;
            r_imm      <= in_imm;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_rd       <= in_rd;
            r_alusrc   <= in_alusrc;
            r_ctrl     <= in_valid ? in_ctrl : 5'b0;
            r_alu_op   <= w_alu_op;
        end
    end

    // x0 is hard-wired zero, so a write targeting it must never be forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (r_rs1 != '0 && exm_regwrite && exm_rd == r_rs1)
            w_fwd_rs1 = exm_result;
        else if (r_rs1 != '0 && mwb_regwrite && mwb_rd == r_rs1)
            w_fwd_rs1 = mwb_result;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (r_rs2 != '0 && exm_regwrite && exm_rd == r_rs2)
            w_fwd_rs2 = exm_result;
        else if (r_rs2 != '0 && mwb_regwrite && mwb_rd == r_rs2)
            w_fwd_rs2 = mwb_result;
    end

    assign out_valid  = r_valid;
    assign alu_a      = w_fwd_rs1;
    assign alu_b      = r_alusrc ? r_imm : w_fwd_rs2;
    assign store_data = w_fwd_rs2;
    assign alu_op     = r_alu_op;
    assign out_rd     = r_rd;
    assign out_ctrl   = r_ctrl;

endmodule
